dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU, port 0)
//  and an external loader/DMA engine (EXT, port 1). One access per cycle; CPU has priority, bounded
//  by an anti-starvation limit. EXT may lock the memory for bursts. Sits between the MEM/WB

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/arb_starve_counter.sv | 36 +++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_t : owner of the last issued access (IDLE when none was issued)
//   owner_t     : per-cycle winner, and the tag of an outstanding read
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    EXT  = 2'd2,
    LOCK = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive CPU grants issued while EXT is waiting.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   cpu_gnt     CPU access issued this cycle
//   ext_gnt     EXT access issued this cycle
//   ext_req     EXT request level
//   at_limit_c  streak has reached STARVE_LIMIT (EXT must win on contention)
module arb_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_gnt,
  input  logic ext_gnt,
  input  logic ext_req,
  output logic at_limit_c
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] streak;

  // Streak clears whenever EXT is served or stops asking; saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (ext_gnt || !ext_req) begin
      streak <= '0;
    end else if (cpu_gnt && (streak != SW'(STARVE_LIMIT))) begin
      streak <= streak + SW'(1);
    end
  end

  assign at_limit_c = (streak == SW'(STARVE_LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (port 0) and an
// external loader/DMA engine (port 1). One access per cycle, CPU priority bounded
// by an anti-starvation limit, EXT may lock the memory for bursts.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata        CPU request; cpu_gnt (comb), cpu_stall, cpu_rvalid
//   ext_req/we/lock/addr/wdata   EXT request; ext_gnt (comb), ext_rvalid
//   rdata                        read data for whichever port has rvalid, else 0
//   mem_addr/wdata/we/re         to the memory; mem_rdata back, 1-cycle latency
// Optional feature macro ARB_STATS_EN adds saturating counters
//   cpu_stall_cnt, ext_wait_cnt, oob_cnt.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned Bits         = 64,
  parameter int unsigned MemSize      = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [Bits-1:0] cpu_addr,
  input  logic [Bits-1:0] cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_stall,
  output logic            cpu_rvalid,
  input  logic            ext_req,
  input  logic            ext_we,
  input  logic            ext_lock,
  input  logic [Bits-1:0] ext_addr,
  input  logic [Bits-1:0] ext_wdata,
  output logic            ext_gnt,
  output logic            ext_rvalid,
  output logic [Bits-1:0] rdata,
  output logic [Bits-1:0] mem_addr,
  output logic [Bits-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
`ifdef ARB_STATS_EN
  output logic [31:0]     cpu_stall_cnt,
  output logic [31:0]     ext_wait_cnt,
  output logic [15:0]     oob_cnt,
`endif
  input  logic [Bits-1:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || MemSize < 1) begin : g_bad_param
    $error("dmem_arbiter: STARVE_LIMIT and MemSize must be >= 1");
  end

  arb_state_t state, state_nxt;
  owner_t     win;
  owner_t     rd_tag;
  logic       at_limit_c;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .cpu_gnt   (cpu_gnt),
    .ext_gnt   (ext_gnt),
    .ext_req   (ext_req),
    .at_limit_c(at_limit_c)
  );

  // Winner selection; held off during reset so every output reads 0.
  // A held lock only counts while EXT still requests and still asserts ext_lock.
  always_comb begin
    win = OWN_NONE;
    if (!rst) begin
      win = OWN_NONE;
    end else if (state == LOCK && ext_req && ext_lock) begin
      win = OWN_EXT;
    end else if (cpu_req && ext_req && at_limit_c) begin
      win = OWN_EXT;
    end else if (cpu_req) begin
      win = OWN_CPU;
    end else if (ext_req) begin
      win = OWN_EXT;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: the owner of the access issued this cycle.
  always_comb begin
    state_nxt = IDLE;
    case (win)
      OWN_CPU: state_nxt = CPU;
      OWN_EXT: state_nxt = ext_lock ? LOCK : EXT;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants, stall and memory mux.
  always_comb begin
    cpu_gnt   = 1'b0;
    ext_gnt   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (win)
      OWN_CPU: begin
        cpu_gnt   = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_re    = ~cpu_we;
      end
      OWN_EXT: begin
        ext_gnt   = 1'b1;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_we    = ext_we;
        mem_re    = ~ext_we;
      end
      default: ;
    endcase
    cpu_stall = rst & cpu_req & ~cpu_gnt;
  end

  // Tag of the read issued this cycle; its data returns next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_tag <= OWN_NONE;
    end else begin
      rd_tag <= mem_re ? win : OWN_NONE;
    end
  end

  assign cpu_rvalid = (rd_tag == OWN_CPU);
  assign ext_rvalid = (rd_tag == OWN_EXT);
  assign rdata      = (cpu_rvalid || ext_rvalid) ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  logic oob_c;
  logic ext_wait_c;

  assign oob_c      = (cpu_gnt || ext_gnt) && (mem_addr >= Bits'(MemSize));
  assign ext_wait_c = rst & ext_req & ~ext_gnt;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_stall_cnt <= '0;
      ext_wait_cnt  <= '0;
      oob_cnt       <= '0;
    end else begin
      if (cpu_stall && (cpu_stall_cnt != '1)) cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
      if (ext_wait_c && (ext_wait_cnt != '1)) ext_wait_cnt <= ext_wait_cnt + 32'd1;
      if (oob_c && (oob_cnt != '1))           oob_cnt <= oob_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural reference model.
module tb_dmem_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned MSIZE = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [63:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
`ifdef ARB_STATS_EN
  logic [31:0] cpu_stall_cnt, ext_wait_cnt;
  logic [15:0] oob_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.Bits(64), .MemSize(MSIZE), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
`ifdef ARB_STATS_EN
    .cpu_stall_cnt(cpu_stall_cnt), .ext_wait_cnt(ext_wait_cnt), .oob_cnt(oob_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  // Memory behind the arbiter: 1-cycle read latency, addresses alias mod 256.
  logic [63:0] tb_mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= tb_mem[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model state: what the arbiter must be doing, from the rules.
  logic [63:0] ref_mem [256] = '{default: '0};
  int          m_streak = 0;    // consecutive CPU wins while EXT waited
  bit          m_locked = 0;    // last access was a locked EXT grant
  int          m_pend   = 0;    // 0 none, 1 CPU read, 2 EXT read outstanding
  logic [63:0] m_pdata  = '0;
  int          m_stall = 0, m_wait = 0, m_oob = 0;
  logic        e_cg, e_eg, e_we, e_re;
  logic [63:0] e_addr, e_wd;

  // Compare process: every cycle, mid-cycle when inputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_ext_gnt", ext_gnt, 0);
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_ext_rvalid", ext_rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_re", mem_re, 0);
      m_streak = 0; m_locked = 0; m_pend = 0; m_pdata = '0;
      m_stall = 0; m_wait = 0; m_oob = 0;
    end else begin
      e_cg = 1'b0;
      e_eg = 1'b0;
      if (m_locked && ext_req && ext_lock)                  e_eg = 1'b1;
      else if (cpu_req && ext_req && m_streak == int'(LIMIT)) e_eg = 1'b1;
      else if (cpu_req)                                     e_cg = 1'b1;
      else if (ext_req)                                     e_eg = 1'b1;
      e_addr = e_cg ? cpu_addr  : (e_eg ? ext_addr  : 64'd0);
      e_wd   = e_cg ? cpu_wdata : (e_eg ? ext_wdata : 64'd0);
      e_we   = e_cg ? cpu_we    : (e_eg ? ext_we    : 1'b0);
      e_re   = (e_cg || e_eg) && !e_we;

      chk("cpu_gnt", cpu_gnt, e_cg);
      chk("ext_gnt", ext_gnt, e_eg);
      chk("cpu_stall", cpu_stall, cpu_req && !e_cg);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("mem_we", mem_we, e_we);
      chk("mem_re", mem_re, e_re);
      chk("cpu_rvalid", cpu_rvalid, m_pend == 1);
      chk("ext_rvalid", ext_rvalid, m_pend == 2);
      chk("rdata", rdata, (m_pend != 0) ? m_pdata : 64'd0);

      if (cpu_req && !e_cg) m_stall++;
      if (ext_req && !e_eg) m_wait++;
      if ((e_cg || e_eg) && e_addr >= 64'(MSIZE)) m_oob++;
`ifdef ARB_STATS_EN
      // Counters show the totals up to the previous cycle.
      chk("cpu_stall_cnt", cpu_stall_cnt, m_stall - ((cpu_req && !e_cg) ? 1 : 0));
      chk("ext_wait_cnt", ext_wait_cnt, m_wait - ((ext_req && !e_eg) ? 1 : 0));
      chk("oob_cnt", oob_cnt, m_oob - (((e_cg || e_eg) && e_addr >= 64'(MSIZE)) ? 1 : 0));
`endif

      // Advance the model to the next cycle.
      if (e_we) ref_mem[e_addr[7:0]] = e_wd;
      if (e_re) begin
        m_pend  = e_cg ? 1 : 2;
        m_pdata = ref_mem[e_addr[7:0]];
      end else begin
        m_pend = 0;
      end
      if (e_eg || !ext_req)     m_streak = 0;
      else if (e_cg)            m_streak = (m_streak < int'(LIMIT)) ? m_streak + 1 : m_streak;
      m_locked = e_eg && ext_lock;
    end
  end

  task automatic drive(input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                       input logic er, input logic ew, input logic el,
                       input logic [63:0] ea, input logic [63:0] ed);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_lock = el; ext_addr = ea; ext_wdata = ed;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] g_cpu, g_stall;
  logic [7:0] g_ext, g_st3;

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // EXT write 0xAB to addr 5, then CPU reads it back.
    drive(0, 0, 0, 0, 1, 1, 0, 64'd5, 64'hAB);
    @(negedge clk); chk("t1_ext_wr_gnt", ext_gnt, 1);
    step();
    drive(1, 0, 64'd5, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t1_cpu_gnt", cpu_gnt, 1); chk("t1_mem_re", mem_re, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t1_cpu_rvalid", cpu_rvalid, 1); chk("t1_rdata", rdata, 64'hAB);
    step();

    // EXT write 0x55 to addr 7, CPU read of addr 7 in the very next cycle.
    drive(0, 0, 0, 0, 1, 1, 0, 64'd7, 64'h55);
    step();
    drive(1, 0, 64'd7, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t4_cpu_rvalid", cpu_rvalid, 1); chk("t4_rdata", rdata, 64'h55);
    step();

    // Sustained contention: CPU x4, EXT x1, repeated.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 64'(i), 64'(i), 1, 1, 0, 64'(i + 100), 64'(i));
      @(negedge clk);
      g_cpu   = {g_cpu[8:0], cpu_gnt};
      g_stall = {g_stall[8:0], cpu_stall};
      step();
    end
    chk("t2_cpu_pattern", 64'(g_cpu), 64'(10'b1111011110));
    chk("t2_stall_pattern", 64'(g_stall), 64'(10'b0000100001));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Locked burst: EXT wins at the limit, keeps the memory while locked, CPU after drop.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 64'd20, 64'd1, 1, 1, (i < 7), 64'(30 + i), 64'(i));
      @(negedge clk);
      g_ext = {g_ext[6:0], ext_gnt};
      g_st3 = {g_st3[6:0], cpu_stall};
      step();
    end
    chk("t3_ext_pattern", 64'(g_ext), 64'(8'b00001110));
    chk("t3_stall_pattern", 64'(g_st3), 64'(8'b00001110));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset between a CPU read grant and its data cycle discards the read.
    drive(1, 0, 64'd5, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t5_cpu_gnt", cpu_gnt, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t5_no_rvalid", cpu_rvalid, 0);
    chk("t5_rdata", rdata, 0);
    chk("t5_gnt_in_rst", cpu_gnt, 0);
    chk("t5_stall_in_rst", cpu_stall, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t5_after_rst_rvalid", cpu_rvalid, 0);
    step();
    // From IDLE after reset a lone CPU request wins immediately.
    drive(1, 1, 64'(MSIZE), 64'd9, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t5_cpu_after_rst", cpu_gnt, 1);
    step();

    // Randomized traffic, including out-of-range addresses.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
            64'($urandom_range(0, MSIZE + 7)), {$urandom, $urandom},
            $urandom_range(0, 99) < 50, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 30,
            64'($urandom_range(0, MSIZE + 7)), {$urandom, $urandom});
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
